// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with a split lookahead adder.
// Low half adds in stage 1, high half in stage 2 via a registered carry.
module alu_cla #(
  parameter int W     = 16,
  parameter int GROUP = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = W / GROUP;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic         gg;
  logic         pg;
  logic         cg;
  logic         ci;

  assign g = a & b;
  assign p = a ^ b;

  // group generate/propagate, group carry chain, then bit sums per group
  always_comb begin
    sum = '0;
    cg  = cin;
    gg  = 1'b0;
    pg  = 1'b1;
    ci  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        pg = pg & p[j*GROUP+i];
      end
      ci = cg;
      for (int i = 0; i < GROUP; i++) begin
        sum[j*GROUP+i] = p[j*GROUP+i] ^ ci;
        ci = g[j*GROUP+i] | (p[j*GROUP+i] & ci);
      end
      cg = gg | (pg & cg);
    end
    cout = cg;
  end
endmodule

module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_carry
);
  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  logic             s1_valid;
  logic             s2_load;
  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] logic_res;
  logic [HALF-1:0]  lo_sum;
  logic             lo_carry;

  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [HALF-1:0]  s1_lo_sum;
  logic             s1_lo_carry;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_b_hi;
  logic [WIDTH-1:0] s1_logic;

  logic [HALF-1:0]  hi_sum;
  logic             co;
  logic             v;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_cy;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;
  assign is_sub   = (in_op == OP_SUB) || (in_op == OP_SLT)
                 || (in_op == OP_SLTU);
  assign b_x      = is_sub ? ~in_b : in_b;

  // full-width logic result, registered alongside the add operands
  always_comb begin
    logic_res = '0;
    unique case (in_op)
      OP_AND:  logic_res = in_a & in_b;
      OP_OR:   logic_res = in_a | in_b;
      OP_XOR:  logic_res = in_a ^ in_b;
      OP_NOR:  logic_res = ~(in_a | in_b);
      default: logic_res = '0;
    endcase
  end

  alu_cla #(.W(HALF), .GROUP(GROUP)) u_lo (
    .a    (in_a[HALF-1:0]),
    .b    (b_x[HALF-1:0]),
    .cin  (is_sub),
    .sum  (lo_sum),
    .cout (lo_carry)
  );

  alu_cla #(.W(HALF), .GROUP(GROUP)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .cin  (s1_lo_carry),
    .sum  (hi_sum),
    .cout (co)
  );

  // stage 1 register: low-half sum plus everything stage 2 needs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_op       <= '0;
      s1_tag      <= '0;
      s1_lo_sum   <= '0;
      s1_lo_carry <= 1'b0;
      s1_a_hi     <= '0;
      s1_b_hi     <= '0;
      s1_logic    <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_load);
      if (accept) begin
        s1_op       <= in_op;
        s1_tag      <= in_tag;
        s1_lo_sum   <= lo_sum;
        s1_lo_carry <= lo_carry;
        s1_a_hi     <= in_a[WIDTH-1:HALF];
        s1_b_hi     <= b_x[WIDTH-1:HALF];
        s1_logic    <= logic_res;
      end
    end
  end

  // stage 2: finish the sum, pick the result and derive flags
  always_comb begin
    v = (s1_a_hi[HALF-1] == s1_b_hi[HALF-1])
     && (hi_sum[HALF-1] != s1_a_hi[HALF-1]);
    res     = '0;
    res_ovf = 1'b0;
    res_cy  = 1'b0;
    unique case (s1_op)
      OP_ADD, OP_SUB: begin
        res     = {hi_sum, s1_lo_sum};
        res_ovf = v;
        res_cy  = co;
      end
      OP_SLT: begin
        res[0] = hi_sum[HALF-1] ^ v;
        res_cy = co;
      end
      OP_SLTU: begin
        res[0] = ~co;
        res_cy = co;
      end
      default: res = s1_logic;
    endcase
  end

  // output register: loads on advance, holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_tag      <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_carry    <= 1'b0;
    end else if (s2_load) begin
      out_valid    <= 1'b1;
      out_result   <= res;
      out_tag      <= s1_tag;
      out_zero     <= (res == '0);
      out_overflow <= res_ovf;
      out_carry    <= res_cy;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with a scoreboard queue.
// Expected results come from an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic [4:0]   t;
    logic         z;
    logic         v;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [4:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_tag;
  logic         out_zero;
  logic         out_overflow;
  logic         out_carry;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ret    = 0;
  exp_t q[$];
  exp_t e;

  alu_pipe #(.WIDTH(32), .GROUP(4), .TAG_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_carry    (out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a,
                                 logic [W-1:0] b, logic [4:0] t);
    exp_t m;
    logic [W:0] s;
    m   = '0;
    m.t = t;
    s   = '0;
    case (op)
      3'b000: m.r = a & b;
      3'b001: m.r = a | b;
      3'b110: m.r = a ^ b;
      3'b111: m.r = ~(a | b);
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        m.r = s[W-1:0];
        m.c = s[W];
        m.v = (a[W-1] == b[W-1]) && (m.r[W-1] != a[W-1]);
      end
      3'b011: begin
        m.r = a - b;
        m.c = (a >= b);
        m.v = (a[W-1] != b[W-1]) && (m.r[W-1] != a[W-1]);
      end
      3'b100: begin
        m.r = {31'b0, ($signed(a) < $signed(b))};
        m.c = (a >= b);
      end
      default: begin
        m.r = {31'b0, (a < b)};
        m.c = (a >= b);
      end
    endcase
    m.z = (m.r == '0);
    return m;
  endfunction

  // scoreboard: pop on retire, push on accept
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("stale_output", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("result", 64'(out_result), 64'(e.r));
        check("tag", 64'(out_tag), 64'(e.t));
        check("flags_zvc", 64'({out_zero, out_overflow, out_carry}),
              64'({e.z, e.v, e.c}));
        n_ret++;
      end
    end
    if (in_valid && in_ready)
      q.push_back(model(in_op, in_a, in_b, in_tag));
  end

  task automatic send(logic [2:0] op, logic [W-1:0] a,
                      logic [W-1:0] b, logic [4:0] t);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  logic [2:0]   bop[6];
  logic [W-1:0] ba[6];
  logic [W-1:0] bb[6];
  logic [W-1:0] hold_r;
  logic [4:0]   hold_t;
  logic [2:0]   hold_f;
  int           idx;
  int           r0;
  logic         acc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'({out_zero, out_overflow, out_carry}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
    check("lat_not_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("add_ovf_result", 64'(out_result), 64'h8000_0000);
    check("add_ovf_flags", 64'({out_zero, out_overflow, out_carry}),
          64'b010);
    check("add_ovf_tag", 64'(out_tag), 64'd3);

    send(3'b011, 32'd5, 32'd5, 5'd1);
    send(3'b011, 32'd0, 32'd1, 5'd2);
    send(3'b100, 32'hFFFF_FFFF, 32'd1, 5'd4);
    send(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd5);
    send(3'b010, 32'h0000_FFFF, 32'd1, 5'd6);
    send(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
    send(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8);
    send(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9);
    send(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10);
    send(3'b011, 32'h8000_0000, 32'd1, 5'd11);
    send(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 5'd12);
    drain();
    check("directed_retired", 64'(n_ret), 64'd12);

    for (int i = 0; i < 6; i++) begin
      bop[i] = 3'($urandom_range(0, 7));
      ba[i]  = $urandom;
      bb[i]  = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_op    = bop[idx];
      in_a     = ba[idx];
      in_b     = bb[idx];
      in_tag   = 5'(idx + 16);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (c == 1) begin
        hold_r = out_result;
        hold_t = out_tag;
        hold_f = {out_zero, out_overflow, out_carry};
      end
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_result", 64'(out_result), 64'(hold_r));
    check("bp_hold_tag", 64'(out_tag), 64'(hold_t));
    check("bp_hold_flags", 64'({out_zero, out_overflow, out_carry}),
          64'(hold_f));

    out_ready = 1'b1;
    r0 = n_ret;
    for (int c = 0; c < 6; c++) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        in_op    = bop[idx];
        in_a     = ba[idx];
        in_b     = bb[idx];
        in_tag   = 5'(idx + 16);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd6);
    check("bp_one_per_cycle", 64'(n_ret - r0), 64'd6);
    check("bp_queue_empty", 64'(q.size()), 64'd0);

    out_ready = 1'b0;
    send(3'b010, 32'd100, 32'd23, 5'd20);
    send(3'b110, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd21);
    rst = 1'b1;
    q.delete();
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    r0 = n_ret;
    repeat (3) @(posedge clk);
    #1;
    check("no_stale_valid", 64'(out_valid), 64'd0);
    send(3'b011, 32'd7, 32'd9, 5'd22);
    drain();
    check("post_rst_retired", 64'(n_ret - r0), 64'd1);

    idx = 0;
    r0 = n_ret;
    for (int c = 0; c < 400 && idx < 30; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 3'($urandom_range(0, 7));
      in_a      = $urandom;
      in_b      = (c % 5 == 0) ? in_a : $urandom;
      in_tag    = 5'(idx);
      out_ready = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_accepted", 64'(idx), 64'd30);
    check("rand_retired", 64'(n_ret - r0), 64'd30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
